// File: rtl/rangefinder_pkg.sv
// Shared rangefinder types: echo reader FSM states and default widths.
// Imported by echo_reader and echo_peak_tracker.
package rangefinder_pkg;

  localparam int RF_ADDR_W  = 8;
  localparam int RF_DATA_W  = 12;
  localparam int RF_COORD_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } rf_state_e;

endpackage

// File: rtl/echo_peak_tracker.sv
// Tracks the earliest strict maximum and first threshold crossing of a beat stream.
// Ports: i_clk, i_rst_n (sync, low), i_clear, i_valid/i_data/i_idx beat, i_thresh; o_* results.
module echo_peak_tracker
  import rangefinder_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_thresh,
  output logic [DATA_W-1:0] o_peak_amp,
  output logic [ADDR_W-1:0] o_peak_idx,
  output logic              o_cross_found,
  output logic [ADDR_W-1:0] o_cross_idx
);

  logic [DATA_W-1:0] r_peak_amp;
  logic [ADDR_W-1:0] r_peak_idx;
  logic              r_cross_found;
  logic [ADDR_W-1:0] r_cross_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_peak_amp    <= '0;
      r_peak_idx    <= '0;
      r_cross_found <= 1'b0;
      r_cross_idx   <= '0;
    end else if (i_valid) begin
      // strict compare keeps the earliest maximum
      if (i_data > r_peak_amp) begin
        r_peak_amp <= i_data;
        r_peak_idx <= i_idx;
      end
      if (!r_cross_found && i_data >= i_thresh) begin
        r_cross_found <= 1'b1;
        r_cross_idx   <= i_idx;
      end
    end
  end

  assign o_peak_amp    = r_peak_amp;
  assign o_peak_idx    = r_peak_idx;
  assign o_cross_found = r_cross_found;
  assign o_cross_idx   = r_cross_idx;

endmodule

// File: rtl/echo_reader.sv
// Reads back a recorded echo over Avalon-MM and reports peak and threshold crossing.
// Ports: ref_clk, reset (sync, low), recorder status in, av_* master, busy/result outputs.
module echo_reader
  import rangefinder_pkg::*;
#(
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W,
  parameter int COORD_W = RF_COORD_W
) (
  input  logic               ref_clk,
  input  logic               reset,
  input  logic               buffer_full,
  input  logic [ADDR_W-1:0]  ram_ptr,
  input  logic [ADDR_W-1:0]  sample_size,
  input  logic [COORD_W-1:0] pulse_abs_coord,
  input  logic [DATA_W-1:0]  threshold,
  output logic               av_cs,
  output logic               av_read,
  output logic [ADDR_W-1:0]  av_addr,
  input  logic               av_waitrequest,
  input  logic [DATA_W-1:0]  av_readdata,
  input  logic               av_readdatavalid,
  output logic               busy,
  output logic               result_valid,
  output logic [DATA_W-1:0]  peak_amp,
  output logic [ADDR_W-1:0]  peak_idx,
  output logic [COORD_W-1:0] echo_coord,
  output logic               cross_found,
  output logic [ADDR_W-1:0]  cross_idx
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  rf_state_e          r_state;
  rf_state_e          w_next;
  logic               r_bf_prev;
  logic [ADDR_W-1:0]  r_size;
  logic [COORD_W-1:0] r_coord;
  logic [DATA_W-1:0]  r_thresh;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_rd_cnt;
  logic [ADDR_W-1:0]  r_beats;
  logic               r_result_valid;
  logic [COORD_W-1:0] r_echo_coord;

  logic               w_rise;
  logic               w_rd;
  logic               w_accept;
  logic               w_beat;
  logic               w_busy;
  logic               w_clear;
  logic [ADDR_W-1:0]  w_peak_idx;

  assign w_rise  = buffer_full & ~r_bf_prev;
  assign w_clear = (r_state == ST_SETUP);

  always_ff @(posedge ref_clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_rd     = 1'b0;
    w_accept = 1'b0;
    w_busy   = 1'b1;
    w_beat   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_rise) w_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (sample_size == '0) w_next = ST_DONE;
        else                   w_next = ST_READ;
      end
      ST_READ: begin
        w_rd     = 1'b1;
        w_accept = !av_waitrequest;
        if (w_accept && r_rd_cnt == r_size - ONE)
          w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_beats == r_size) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    // beats only count while a transfer is outstanding
    if ((r_state == ST_READ || r_state == ST_DRAIN)
        && av_readdatavalid && r_beats != r_size)
      w_beat = 1'b1;
  end

  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      r_bf_prev      <= 1'b0;
      r_size         <= '0;
      r_coord        <= '0;
      r_thresh       <= '0;
      r_addr         <= '0;
      r_rd_cnt       <= '0;
      r_beats        <= '0;
      r_result_valid <= 1'b0;
      r_echo_coord   <= '0;
    end else begin
      r_bf_prev      <= buffer_full;
      r_result_valid <= 1'b0;
      if (r_state == ST_SETUP) begin
        r_size   <= sample_size;
        r_coord  <= pulse_abs_coord;
        r_thresh <= threshold;
        // oldest sample sits sample_size behind the write pointer
        r_addr   <= ram_ptr - sample_size;
        r_rd_cnt <= '0;
        r_beats  <= '0;
      end
      if (w_accept) begin
        r_addr   <= r_addr + ONE;
        r_rd_cnt <= r_rd_cnt + ONE;
      end
      if (w_beat) r_beats <= r_beats + ONE;
      if (r_state == ST_DONE) begin
        r_result_valid <= 1'b1;
        r_echo_coord   <= r_coord + COORD_W'(w_peak_idx);
      end
    end
  end

  echo_peak_tracker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_peak (
    .i_clk         (ref_clk),
    .i_rst_n       (reset),
    .i_clear       (w_clear),
    .i_valid       (w_beat),
    .i_data        (av_readdata),
    .i_idx         (r_beats),
    .i_thresh      (r_thresh),
    .o_peak_amp    (peak_amp),
    .o_peak_idx    (w_peak_idx),
    .o_cross_found (cross_found),
    .o_cross_idx   (cross_idx)
  );

  assign av_cs        = w_rd;
  assign av_read      = w_rd;
  assign av_addr      = r_addr;
  assign busy         = w_busy;
  assign result_valid = r_result_valid;
  assign peak_idx     = w_peak_idx;
  assign echo_coord   = r_echo_coord;

endmodule

// File: tb/tb_echo_reader.sv
// Self-checking bench for echo_reader: Avalon slave model plus
// a queue-based reference of peak/crossing results.
module tb_echo_reader;

  logic        ref_clk = 1'b0;
  logic        reset = 1'b0;
  logic        buffer_full = 1'b0;
  logic [7:0]  ram_ptr = '0;
  logic [7:0]  sample_size = '0;
  logic [12:0] pulse_abs_coord = '0;
  logic [11:0] threshold = '0;
  logic        av_cs, av_read;
  logic [7:0]  av_addr;
  logic        av_waitrequest = 1'b0;
  logic [11:0] av_readdata = '0;
  logic        av_readdatavalid = 1'b0;
  logic        busy, result_valid;
  logic [11:0] peak_amp;
  logic [7:0]  peak_idx, cross_idx;
  logic [12:0] echo_coord;
  logic        cross_found;

  echo_reader dut (
    .ref_clk          (ref_clk),
    .reset            (reset),
    .buffer_full      (buffer_full),
    .ram_ptr          (ram_ptr),
    .sample_size      (sample_size),
    .pulse_abs_coord  (pulse_abs_coord),
    .threshold        (threshold),
    .av_cs            (av_cs),
    .av_read          (av_read),
    .av_addr          (av_addr),
    .av_waitrequest   (av_waitrequest),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .busy             (busy),
    .result_valid     (result_valid),
    .peak_amp         (peak_amp),
    .peak_idx         (peak_idx),
    .echo_coord       (echo_coord),
    .cross_found      (cross_found),
    .cross_idx        (cross_idx)
  );

  always #5 ref_clk = ~ref_clk;

  logic [11:0] mem [256];
  logic [11:0] pend[$];
  logic [7:0]  addr_log[$];
  int rd_seen, stall_left, rv_count, cs_bad;
  bit rand_stall, spurious;
  int n_vec, n_err;

  // Avalon slave: read data returned one cycle after acceptance
  always @(negedge ref_clk) begin
    if (result_valid) rv_count++;
    if (av_cs !== av_read) cs_bad++;
    if (!reset) begin
      pend.delete();
      av_readdatavalid = 1'b0;
      av_waitrequest = 1'b0;
    end else begin
      if (pend.size() > 0) begin
        av_readdatavalid = 1'b1;
        av_readdata = pend.pop_front();
      end else if (spurious && !busy) begin
        av_readdatavalid = 1'b1;
        av_readdata = 12'hfff;
      end else begin
        av_readdatavalid = 1'b0;
        av_readdata = 12'($urandom);
      end
      av_waitrequest = 1'b0;
      if (av_read) begin
        if (rd_seen == 1 && stall_left > 0) begin
          av_waitrequest = 1'b1;
          stall_left--;
        end else if (rand_stall) begin
          av_waitrequest = ($urandom_range(0, 3) == 0);
        end
        if (!av_waitrequest) begin
          pend.push_back(mem[av_addr]);
          addr_log.push_back(av_addr);
          rd_seen++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic run(input logic [7:0] ptr, input logic [7:0] size,
                     input logic [12:0] coord, input logic [11:0] thr,
                     input bit toggle);
    logic [11:0] s[$];
    logic [11:0] mx[$];
    int fi[$];
    int exp_pk, exp_pi, exp_cf, exp_ci, exp_ec, cyc, bad, rv0;
    logic [7:0] a0;
    a0 = ptr - size;
    for (int k = 0; k < int'(size); k++) s.push_back(mem[8'(a0 + k)]);
    exp_pk = 0;
    exp_pi = 0;
    if (s.size() > 0) begin
      mx = s.max();
      exp_pk = mx[0];
      fi = s.find_first_index with (item == mx[0]);
      exp_pi = fi[0];
    end
    fi = s.find_first_index with (item >= thr);
    exp_cf = (fi.size() > 0) ? 1 : 0;
    exp_ci = (fi.size() > 0) ? fi[0] : 0;
    exp_ec = (int'(coord) + exp_pi) % 8192;
    addr_log.delete();
    rd_seen = 0;
    cs_bad = 0;
    rv0 = rv_count;
    @(negedge ref_clk);
    ram_ptr = ptr;
    sample_size = size;
    pulse_abs_coord = coord;
    threshold = thr;
    buffer_full = 1'b1;
    cyc = 0;
    do begin
      @(negedge ref_clk);
      cyc++;
      if (toggle && cyc >= 2 && cyc < 10)
        buffer_full = (cyc == 9) ? 1'b1 : cyc[0];
    end while (!result_valid && cyc < 3000);
    chk("result_valid_seen", result_valid, 1);
    if (size == 0) chk("zero_size_latency", cyc, 3);
    chk("peak_amp", peak_amp, exp_pk);
    chk("peak_idx", peak_idx, exp_pi);
    chk("cross_found", cross_found, exp_cf);
    chk("cross_idx", cross_idx, exp_ci);
    chk("echo_coord", echo_coord, exp_ec);
    bad = 0;
    foreach (addr_log[i]) if (addr_log[i] !== 8'(a0 + i)) bad++;
    chk("addr_sequence", bad, 0);
    chk("read_count", addr_log.size(), size);
    @(negedge ref_clk);
    chk("rv_one_cycle", result_valid, 0);
    repeat (5) @(negedge ref_clk);
    chk("idle_no_retrigger", busy, 0);
    chk("rv_pulses", rv_count - rv0, 1);
    chk("cs_eq_read", cs_bad, 0);
    chk("hold_peak", peak_amp, exp_pk);
    buffer_full = 1'b0;
    @(negedge ref_clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rv0;
    n_vec = 0; n_err = 0; rv_count = 0; cs_bad = 0;
    rd_seen = 0; stall_left = 0; rand_stall = 0; spurious = 0;
    foreach (mem[i]) mem[i] = '0;

    repeat (3) @(negedge ref_clk);
    chk("rst_busy", busy, 0);
    chk("rst_av_cs", av_cs, 0);
    chk("rst_av_read", av_read, 0);
    chk("rst_av_addr", av_addr, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_peak_amp", peak_amp, 0);
    chk("rst_cross_found", cross_found, 0);
    chk("rst_echo_coord", echo_coord, 0);
    reset = 1'b1;
    @(negedge ref_clk);

    // ramp 0..15 ending just below write pointer 8
    for (int k = 0; k < 16; k++) mem[8'(248 + k)] = 12'(k);
    run(8'd8, 8'd16, 13'd100, 12'd10, 1'b0);
    chk("ramp_peak_amp", peak_amp, 15);
    chk("ramp_cross_idx", cross_idx, 10);

    run(8'd8, 8'd0, 13'd5, 12'd10, 1'b0);

    stall_left = 3;
    run(8'd8, 8'd16, 13'd100, 12'd10, 1'b0);
    chk("stall_peak_idx", peak_idx, 15);
    chk("stall_left_used", stall_left, 0);

    mem[254] = 12'd5; mem[255] = 12'd9;
    mem[0] = 12'd9; mem[1] = 12'd2;
    run(8'd2, 8'd4, 13'd8190, 12'd20, 1'b0);
    chk("ties_echo_coord", echo_coord, 8191);

    // reset in the middle of a long read burst
    foreach (mem[i]) mem[i] = 12'($urandom_range(1, 4095));
    addr_log.delete();
    @(negedge ref_clk);
    ram_ptr = 8'd77; sample_size = 8'd60; threshold = 12'd4000;
    buffer_full = 1'b1;
    cyc = 0;
    while (addr_log.size() < 5 && cyc < 200) begin
      @(negedge ref_clk);
      cyc++;
    end
    chk("mid_read_reached", (addr_log.size() >= 5) ? 1 : 0, 1);
    rv0 = rv_count;
    reset = 1'b0;
    buffer_full = 1'b0;
    @(negedge ref_clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_av_cs", av_cs, 0);
    chk("mid_rst_av_addr", av_addr, 0);
    chk("mid_rst_peak_amp", peak_amp, 0);
    chk("mid_rst_peak_idx", peak_idx, 0);
    chk("mid_rst_echo_coord", echo_coord, 0);
    reset = 1'b1;
    repeat (4) @(negedge ref_clk);
    chk("mid_rst_no_result", rv_count - rv0, 0);
    run(8'd77, 8'd20, 13'd4000, 12'd3000, 1'b0);

    // buffer_full toggling while busy
    run(8'd200, 8'd30, 13'd8000, 12'd2000, 1'b1);

    rand_stall = 1;
    spurious = 1;
    for (int r = 0; r < 8; r++) begin
      foreach (mem[i]) mem[i] = 12'($urandom_range(0, 63));
      run(8'($urandom), (r == 0) ? 8'd255 : 8'($urandom_range(1, 40)),
          13'($urandom), 12'($urandom_range(0, 70)), r[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
